// File: rtl/uart_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_pkg
// Purpose : shared definitions for the UART transmit scheduler: FSM state
//           encoding and UART frame timing constants.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_t;

    // UART timing: one bit lasts BIT_CLKS clocks, a frame is FRAME_BITS bits
    localparam int BIT_CLKS   = 400;
    localparam int FRAME_BITS = 10;
    localparam int FRAME_CLKS = BIT_CLKS * FRAME_BITS;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Purpose : bundles the requester handshake and the transmitter control
//           signals of the UART transmit scheduler.
// Signals : req_valid/req_data/req_ready - N requesters, byte i at [8*i+7:8*i]
//           tx_data/tx_start/tx_busy/tx_done - transmitter sequencing
//           grant_id - index of requester currently/last served
//           timeout_err - sticky watchdog abort flag
// Modports: slave  - the scheduler
//           master - the environment (requesters + transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int N   = 2,
    parameter int IDW = 1
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic           tx_done;
    logic [IDW-1:0] grant_id;
    logic           timeout_err;

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_data, tx_start, grant_id, timeout_err
    );

    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_data, tx_start, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purpose : combinational round-robin pick. Searches i_ptr+1, i_ptr+2, ...
//           (mod N) and returns the first requester with i_valid set.
// Ports   : i_valid [N]   - pending request mask
//           i_ptr   [IDW] - index served last
//           o_pick  [IDW] - next index to serve (valid only when o_any)
//           o_any         - at least one request pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   i_valid,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_pick,
    output logic           o_any
);
    logic [IDW-1:0] w_hi_pick;
    logic           w_hi_found;
    logic [IDW-1:0] w_lo_pick;

    // Lowest valid index above the pointer, and lowest valid index at/below it;
    // scanning downwards leaves the lowest match in each half.
    always_comb begin
        w_hi_pick  = '0;
        w_hi_found = 1'b0;
        w_lo_pick  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_valid[j] && (j > int'(i_ptr))) begin
                w_hi_found = 1'b1;
                w_hi_pick  = IDW'(j);
            end else if (i_valid[j]) begin
                w_lo_pick  = IDW'(j);
            end else begin
                w_hi_found = w_hi_found;
            end
        end
    end

    assign o_pick = w_hi_found ? w_hi_pick : w_lo_pick;
    assign o_any  = |i_valid;

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Purpose : shares one UART transmitter between N byte requesters. Grants one
//           byte per round-robin turn, pulses TX_START with the byte, then waits
//           for TX_DONE. A watchdog aborts a frame that never completes and sets
//           a sticky error flag.
// Ports   : i_clk   - system clock, rising edge
//           i_rst_n - asynchronous active-low reset
//           bus     - uart_tx_scheduler_if.slave (requesters + transmitter)
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N           = 2,
    parameter int IDW         = 1,
    parameter int TIMEOUT_CYC = 8192,
    parameter int CNT_W       = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    uart_tx_scheduler_if.slave   bus
);
    sched_state_t   r_state;
    sched_state_t   w_state_nxt;

    logic [N-1:0]   r_req_ready, w_ready_nxt;
    logic           r_tx_start,  w_start_nxt;
    logic [7:0]     r_tx_data,   w_data_nxt;
    logic [IDW-1:0] r_grant_id,  w_gid_nxt;
    logic [IDW-1:0] r_ptr,       w_ptr_nxt;
    logic           r_timeout_err, w_err_nxt;
    logic [CNT_W-1:0] r_wd,      w_wd_nxt;

    logic [IDW-1:0] w_pick;
    logic           w_any;
    logic           w_grant;
    logic           w_expire;
    logic [7:0]     w_sel_data;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_any   (w_any)
    );

    // A busy transmitter in IDLE is owned by someone else, so no grant then.
    assign w_grant  = (r_state == ST_IDLE) && w_any && !bus.tx_busy;
    assign w_expire = (r_wd == CNT_W'(TIMEOUT_CYC - 1));

    // Byte of the requester picked by the arbiter
    always_comb begin
        w_sel_data = 8'h00;
        for (int j = 0; j < N; j++) begin
            w_sel_data = (w_pick == IDW'(j)) ? bus.req_data[8*j +: 8] : w_sel_data;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; TX_DONE takes priority over a watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_grant ? ST_START : ST_IDLE;
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = (bus.tx_done || w_expire) ? ST_IDLE : ST_WAIT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and watchdog
    always_comb begin
        w_ready_nxt = '0;
        w_start_nxt = 1'b0;
        w_data_nxt  = r_tx_data;
        w_gid_nxt   = r_grant_id;
        w_ptr_nxt   = r_ptr;
        w_err_nxt   = r_timeout_err;
        w_wd_nxt    = r_wd;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_ready_nxt = {{(N-1){1'b0}}, 1'b1} << w_pick;
                    w_start_nxt = 1'b1;
                    w_data_nxt  = w_sel_data;
                    w_gid_nxt   = w_pick;
                    w_ptr_nxt   = w_pick;
                end else begin
                    w_start_nxt = 1'b0;
                end
            end
            ST_START: w_wd_nxt = '0;
            ST_WAIT: begin
                if (bus.tx_done) begin
                    w_wd_nxt = r_wd;
                end else if (w_expire) begin
                    w_err_nxt = 1'b1;
                end else if (r_wd != {CNT_W{1'b1}}) begin
                    w_wd_nxt = r_wd + CNT_W'(1);
                end else begin
                    w_wd_nxt = r_wd;
                end
            end
            default: w_start_nxt = 1'b0;
        endcase
    end

    // Output, pointer and watchdog registers; pointer resets to N-1 so
    // requester 0 has first priority
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_ready   <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant_id    <= '0;
            r_ptr         <= IDW'(N - 1);
            r_timeout_err <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_req_ready   <= w_ready_nxt;
            r_tx_start    <= w_start_nxt;
            r_tx_data     <= w_data_nxt;
            r_grant_id    <= w_gid_nxt;
            r_ptr         <= w_ptr_nxt;
            r_timeout_err <= w_err_nxt;
            r_wd          <= w_wd_nxt;
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench: a behavioural model (round-robin search over a last-served
// index, frame age counted from TX_START) predicts every output each cycle;
// directed points pin literal values for reset, single grant, round robin,
// blocking, timeout and done-on-last-cycle. Ends with a randomized run.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;
    localparam int N           = 2;
    localparam int IDW         = 1;
    localparam int TIMEOUT_CYC = 8192;
    localparam int CNT_W       = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_scheduler_if #(.N(N), .IDW(IDW)) bus ();

    uart_tx_scheduler #(.N(N), .IDW(IDW), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Scenario controls, written only by the main sequence
    logic           auto_req   = 1'b0;
    logic           rand_busy  = 1'b0;
    logic           force_busy = 1'b0;
    int             frame_len  = 4000;   // >0 fixed, 0 never completes, <0 random
    logic [N-1:0]   dir_valid  = '0;
    logic [8*N-1:0] dir_data   = '0;

    // Literal expectation for one cycle, written only by the main sequence
    logic           pin_en    = 1'b0;
    string          pin_name  = "";
    logic           pin_start = 1'b0;
    logic [N-1:0]   pin_ready = '0;
    logic [7:0]     pin_data  = 8'h00;
    logic [IDW-1:0] pin_gid   = '0;
    logic           pin_err   = 1'b0;

    // Model expectations
    logic           exp_start = 1'b0;
    logic [N-1:0]   exp_ready = '0;
    logic [7:0]     exp_data  = 8'h00;
    logic [IDW-1:0] exp_gid   = '0;
    logic           exp_err   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Requesters and transmitter, driven 1 time unit after each rising edge
    initial begin : drv
        logic [N-1:0] prev_ready;
        logic         tx_active;
        int           tx_cnt;
        int           tx_len;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        prev_ready    = '0;
        tx_active     = 1'b0;
        tx_cnt        = 0;
        tx_len        = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (!rst_n) begin
                tx_active   = 1'b0;
                bus.tx_busy = 1'b0;
                prev_ready  = '0;
            end else if (tx_active) begin
                tx_cnt++;
                if (tx_cnt == tx_len) begin
                    bus.tx_done = 1'b1;
                    bus.tx_busy = 1'b0;
                    tx_active   = 1'b0;
                end
            end else if (bus.tx_start) begin
                tx_active   = 1'b1;
                tx_cnt      = 0;
                bus.tx_busy = 1'b1;
                tx_len = (frame_len > 0) ? frame_len :
                         ((frame_len == 0) ? -1 : int'($urandom_range(30, 1)));
            end else begin
                bus.tx_busy = force_busy | (rand_busy & ($urandom_range(7, 0) == 0));
                bus.tx_done = rand_busy & ($urandom_range(15, 0) == 0);
            end
            if (auto_req) begin
                for (int i = 0; i < N; i++) begin
                    if (prev_ready[i]) begin
                        bus.req_valid[i]       = ($urandom_range(3, 0) != 0);
                        bus.req_data[8*i +: 8] = 8'($urandom);
                    end else if (!bus.req_valid[i]) begin
                        bus.req_valid[i]       = ($urandom_range(3, 0) == 0);
                        bus.req_data[8*i +: 8] = 8'($urandom);
                    end
                end
            end else begin
                bus.req_valid = dir_valid;
                bus.req_data  = dir_data;
            end
            prev_ready = bus.req_ready;
        end
    end

    // Behavioural model: inputs sampled at each rising edge
    initial begin : mdl
        bit m_active;
        int m_age;      // 0 = pulse cycle, k = k-th cycle waiting for completion
        int m_last;
        int c;
        int p;
        bit found;
        m_active = 1'b0;
        m_age    = 0;
        m_last   = N - 1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active  = 1'b0;
                m_age     = 0;
                m_last    = N - 1;
                exp_start = 1'b0;
                exp_ready = '0;
                exp_data  = 8'h00;
                exp_gid   = '0;
                exp_err   = 1'b0;
            end else begin
                exp_start = 1'b0;
                exp_ready = '0;
                if (!m_active) begin
                    if ((bus.req_valid != '0) && !bus.tx_busy) begin
                        found = 1'b0;
                        p     = 0;
                        for (int k = 1; k <= N; k++) begin
                            c = (m_last + k) % N;
                            if (!found && (((bus.req_valid >> c) & N'(1)) != '0)) begin
                                found = 1'b1;
                                p     = c;
                            end
                        end
                        m_active  = 1'b1;
                        m_age     = 0;
                        m_last    = p;
                        exp_start = 1'b1;
                        exp_ready = N'(1) << p;
                        exp_data  = 8'(bus.req_data >> (8 * p));
                        exp_gid   = IDW'(p);
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                end else if (bus.tx_done) begin
                    m_active = 1'b0;
                end else if (m_age >= TIMEOUT_CYC) begin
                    m_active = 1'b0;
                    exp_err  = 1'b1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endfunction

    // Compare on the falling edge, away from the active edge
    initial begin : cmp
        forever begin
            @(negedge clk);
            n_vec++;
            chk("tx_start",    32'(bus.tx_start),    32'(exp_start));
            chk("req_ready",   32'(bus.req_ready),   32'(exp_ready));
            chk("tx_data",     32'(bus.tx_data),     32'(exp_data));
            chk("grant_id",    32'(bus.grant_id),    32'(exp_gid));
            chk("timeout_err", 32'(bus.timeout_err), 32'(exp_err));
            if (pin_en) begin
                n_vec++;
                chk({pin_name, ".start"}, 32'(bus.tx_start),    32'(pin_start));
                chk({pin_name, ".ready"}, 32'(bus.req_ready),   32'(pin_ready));
                chk({pin_name, ".data"},  32'(bus.tx_data),     32'(pin_data));
                chk({pin_name, ".gid"},   32'(bus.grant_id),    32'(pin_gid));
                chk({pin_name, ".err"},   32'(bus.timeout_err), 32'(pin_err));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            pin_en = 1'b0;
            #2;
        end
    endtask

    task automatic pin(input string nm, input logic s, input logic [N-1:0] r,
                       input logic [7:0] d, input logic [IDW-1:0] g, input logic e);
        pin_name  = nm;
        pin_start = s;
        pin_ready = r;
        pin_data  = d;
        pin_gid   = g;
        pin_err   = e;
        pin_en    = 1'b1;
    endtask

    initial begin : main
        step(3);
        pin("reset", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;

        // Single requester
        dir_valid = 2'b01;
        dir_data  = {8'h00, 8'h5A};
        step(2);
        pin("single", 1'b1, 2'b01, 8'h5A, 1'b0, 1'b0);
        dir_valid = 2'b00;
        step(100);

        // Reset in the middle of a frame
        rst_n = 1'b0;
        pin("reset_mid", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;

        // Round robin, 4000-cycle frames: START + 4000 wait + 1 idle = 4002
        dir_valid = 2'b11;
        dir_data  = {8'hB2, 8'hA1};
        step(2);
        pin("rr0", 1'b1, 2'b01, 8'hA1, 1'b0, 1'b0);
        step(4002);
        pin("rr1", 1'b1, 2'b10, 8'hB2, 1'b1, 1'b0);
        step(4002);
        pin("rr2", 1'b1, 2'b01, 8'hA1, 1'b0, 1'b0);
        step(4002);
        pin("rr3", 1'b1, 2'b10, 8'hB2, 1'b1, 1'b0);
        dir_valid = 2'b00;
        step(4010);

        // Busy transmitter in idle blocks granting
        force_busy = 1'b1;
        dir_valid  = 2'b01;
        step(50);
        pin("blocked", 1'b0, 2'b00, 8'hB2, 1'b1, 1'b0);
        force_busy = 1'b0;
        frame_len  = TIMEOUT_CYC;
        step(2);
        pin("unblock", 1'b1, 2'b01, 8'hA1, 1'b0, 1'b0);
        dir_valid = 2'b00;
        step(TIMEOUT_CYC + 1);
        pin("done_last", 1'b0, 2'b00, 8'hA1, 1'b0, 1'b0);

        // Watchdog timeout
        dir_valid = 2'b01;
        frame_len = 0;
        step(2);
        pin("to_start", 1'b1, 2'b01, 8'hA1, 1'b0, 1'b0);
        dir_valid = 2'b00;
        step(TIMEOUT_CYC);
        pin("to_before", 1'b0, 2'b00, 8'hA1, 1'b0, 1'b0);
        step(1);
        pin("to_err", 1'b0, 2'b00, 8'hA1, 1'b0, 1'b1);
        step(20);
        pin("to_sticky", 1'b0, 2'b00, 8'hA1, 1'b0, 1'b1);
        rst_n = 1'b0;
        pin("reset_err", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;
        dir_valid = 2'b11;
        frame_len = -1;
        step(2);
        pin("first_after", 1'b1, 2'b01, 8'hA1, 1'b0, 1'b0);

        // Randomized traffic with foreign busy and stray done pulses
        auto_req  = 1'b1;
        rand_busy = 1'b1;
        step(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
